// File: rtl/round_scheduler.sv
// round_scheduler: multi-round sequencer for the memory game.
// Each round appends one LFSR-chosen note to the sequence. It then hands the
// sequence to the playback and response datapaths using a
// load -> playback -> response handshake. It keeps the score and ends the game
// as won after MAX_NOTES rounds, or as lost on a mistake.
// Optional build macro SCHED_TIMEOUT_EN: the response phase is limited to
// RESP_TIMEOUT cycles, and expiry counts as a loss.
module round_scheduler #(
    parameter int unsigned MAX_NOTES    = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [31:0] RESP_TIMEOUT = 32'd250000000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   done_playback,
    input  logic                   done_response,
    input  logic                   made_mistake,
    output logic                   load_level,
    output logic                   start_playback,
    output logic                   start_response,
    output logic [4*MAX_NOTES-1:0] level_data,
    output logic [3:0]             level_length,
    output logic [7:0]             score,
    output logic                   game_won,
    output logic                   game_lost,
    output logic [3:0]             current_state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_GEN  = 4'd1,
        S_LOAD = 4'd2,
        S_PLAY = 4'd3,
        S_RESP = 4'd4,
        S_NEXT = 4'd5,
        S_WON  = 4'd6,
        S_LOST = 4'd7
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [4*MAX_NOTES-1:0] data_q, data_d;
    logic [3:0]             len_q, len_d;
    logic [7:0]             score_q, score_d;
    logic                   splay_q;
    logic [3:0]             note;
    logic [8:0]             score_sum;
    logic                   timeout;

    // Galois LFSR, x^16+x^14+x^13+x^11+1, free-running so start timing picks the notes
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    assign note      = 4'b0001 << lfsr_q[1:0];
    assign score_sum = {1'b0, score_q} + {5'd0, len_q};

`ifdef SCHED_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;

    assign timeout = (timer_q == RESP_TIMEOUT - 32'd1);

    // Timer restarts at 0 on every RESP entry and counts only while staying in RESP
    always_comb begin
        timer_d = '0;
        if (state_q == S_RESP && state_d == S_RESP) timer_d = timer_q + 32'd1;
    end

    // Response timer register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) timer_q <= '0;
        else         timer_q <= timer_d;
    end
`else
    // RESP never times out. The parameter is still referenced so that both builds share one interface.
    assign timeout = (RESP_TIMEOUT == 32'd0) && 1'b0;
`endif

    // Next-state and datapath updates; unreachable codes fall back to IDLE
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        score_d = score_q;
        case (state_q)
            S_IDLE, S_WON, S_LOST: begin
                if (start) begin
                    data_d  = '0;
                    len_d   = '0;
                    score_d = '0;
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                // Append at nibble index len_q, counted from the MSB; earlier nibbles stay untouched
                for (int i = 0; i < int'(MAX_NOTES); i++) begin
                    if (len_q == 4'(i)) data_d[4*(int'(MAX_NOTES)-1-i) +: 4] = note;
                end
                len_d   = len_q + 4'd1;
                state_d = S_LOAD;
            end
            S_LOAD: state_d = S_PLAY;
            S_PLAY: begin
                // First PLAY cycle is skipped while the playback counter settles
                if (done_playback && !splay_q) state_d = S_RESP;
            end
            S_RESP: begin
                if (made_mistake)       state_d = S_LOST;
                else if (done_response) state_d = S_NEXT;
                else if (timeout)       state_d = S_LOST;
            end
            S_NEXT: begin
                score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                state_d = (len_q == 4'(MAX_NOTES)) ? S_WON : S_GEN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, sequence, score and LFSR registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            data_q  <= '0;
            len_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            len_q   <= len_d;
            score_q <= score_d;
        end
    end

    // start_playback pulse: high for the single cycle after LOAD, which is the first PLAY cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) splay_q <= 1'b0;
        else         splay_q <= (state_q == S_LOAD);
    end

    assign load_level     = (state_q == S_LOAD);
    assign start_playback = splay_q;
    assign start_response = (state_q == S_RESP);
    assign game_won       = (state_q == S_WON);
    assign game_lost      = (state_q == S_LOST);
    assign level_data     = data_q;
    assign level_length   = len_q;
    assign score          = score_q;
    assign current_state  = state_q;

endmodule
